// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and the SRAM responder.
// HREADY is the interconnect's combined ready, so it sits on the master side.
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: word-addressed array, programmable wait states,
// two-cycle ERROR for illegal beats and read-after-write forwarding.
module ahb_lite_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_sram_slave_if.slave  ahb
);

  localparam int IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int NumBytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] ByteSpan = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);
  localparam bit HasWait = (WAIT_STATES > 0);
  localparam logic [3:0] WaitLoad = HasWait ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            waitCnt_q, waitCnt_d;
  logic [IdxW-1:0]       wordIdx_q;
  logic [NumBytes-1:0]   byteEn_q;
  logic                  write_q;
  logic                  legal_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  capture;
  logic                  legal;
  logic                  aligned;
  logic [ADDR_WIDTH:0]   diff;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IdxW-1:0]       newIdx;
  logic [NumBytes-1:0]   newByteEn;
  logic                  commit;
  logic [IdxW-1:0]       readIdx;
  logic                  readIsRead;
  logic                  loadRead;
  logic [DATA_WIDTH-1:0] rdWord;
  logic                  unusedBits;

  function automatic logic [NumBytes-1:0] laneEnables(input logic [1:0] lane,
                                                      input logic [2:0] size);
    case (size)
      3'd0:    return NumBytes'(4'b0001 << lane);
      3'd1:    return lane[1] ? NumBytes'(4'b1100) : NumBytes'(4'b0011);
      default: return '1;
    endcase
  endfunction

  // A borrow out of the subtraction means the address is below the window.
  assign diff   = {1'b0, ahb.HADDR} - {1'b0, BASE_ADDR};
  assign offset = diff[ADDR_WIDTH-1:0];
  assign newIdx = offset[IdxW+1:2];
  assign newByteEn = laneEnables(ahb.HADDR[1:0], ahb.HSIZE);

  always_comb begin
    aligned = 1'b0;
    case (ahb.HSIZE)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (ahb.HADDR[0] == 1'b0);
      3'd2:    aligned = (ahb.HADDR[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal = aligned && !diff[ADDR_WIDTH] && ({1'b0, offset} < ByteSpan);
  assign accept = ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];
  assign unusedBits = ^{ahb.HBURST, ahb.HTRANS[0], offset};

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (!legal) begin
            state_d = S_ERR1;
          end else if (HasWait) begin
            state_d   = S_WAIT;
            waitCnt_d = WaitLoad;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      waitCnt_q <= 4'd0;
      wordIdx_q <= '0;
      byteEn_q  <= '0;
      write_q   <= 1'b0;
      legal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (capture) begin
        wordIdx_q <= newIdx;
        byteEn_q  <= newByteEn;
        write_q   <= ahb.HWRITE;
        legal_q   <= legal;
      end
    end
  end

  // The write of the beat ending now lands on the same edge a new read may load.
  assign commit     = (state_q == S_DATA) && write_q && legal_q;
  assign readIdx    = capture ? newIdx : wordIdx_q;
  assign readIsRead = capture ? !ahb.HWRITE : !write_q;
  assign loadRead   = (state_d == S_DATA) && (capture || (state_q == S_WAIT)) && readIsRead;

  always_comb begin
    rdWord = mem[readIdx];
    if (commit && (readIdx == wordIdx_q)) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (byteEn_q[i]) begin
          rdWord[8*i +: 8] = ahb.HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit && !HRESET) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (byteEn_q[i]) begin
          mem[wordIdx_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hrdata_q <= '0;
    end else if (loadRead) begin
      hrdata_q <= rdWord;
    end
  end

  assign ahb.HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign ahb.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign ahb.HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: three instances with 0, 2 and 3 wait
// states share one driven bus; only the selected target sees HSEL.
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [1:0]  target;

  logic        busReady;
  logic        busResp;
  logic [31:0] busRdata;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave_if bus0 ();
  ahb_lite_sram_slave_if bus2 ();
  ahb_lite_sram_slave_if bus3 ();

  assign bus0.HSEL = hsel && (target == 2'd0);
  assign bus2.HSEL = hsel && (target == 2'd2);
  assign bus3.HSEL = hsel && (target == 2'd3);
  assign {bus0.HADDR, bus2.HADDR, bus3.HADDR}    = {3{haddr}};
  assign {bus0.HTRANS, bus2.HTRANS, bus3.HTRANS} = {3{htrans}};
  assign {bus0.HWRITE, bus2.HWRITE, bus3.HWRITE} = {3{hwrite}};
  assign {bus0.HSIZE, bus2.HSIZE, bus3.HSIZE}    = {3{hsize}};
  assign {bus0.HBURST, bus2.HBURST, bus3.HBURST} = 9'd0;
  assign {bus0.HWDATA, bus2.HWDATA, bus3.HWDATA} = {3{hwdata}};
  assign {bus0.HREADY, bus2.HREADY, bus3.HREADY} = {3{busReady}};

  always_comb begin
    case (target)
      2'd0: begin
        busReady = bus0.HREADYOUT; busResp = bus0.HRESP; busRdata = bus0.HRDATA;
      end
      2'd2: begin
        busReady = bus2.HREADYOUT; busResp = bus2.HRESP; busRdata = bus2.HRDATA;
      end
      default: begin
        busReady = bus3.HREADYOUT; busResp = bus3.HRESP; busRdata = bus3.HRDATA;
      end
    endcase
  end

  ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESET(HRESET), .ahb(bus0));
  ahb_lite_sram_slave #(.WAIT_STATES(2)) dut2 (.HCLK(HCLK), .HRESET(HRESET), .ahb(bus2));
  ahb_lite_sram_slave #(.WAIT_STATES(3)) dut3 (.HCLK(HCLK), .HRESET(HRESET), .ahb(bus3));

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic [31:0] addr, input logic write,
                               input logic [2:0] size);
    hsel   = sel;
    htrans = trans;
    haddr  = addr;
    hwrite = write;
    hsize  = size;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic rdy, input logic resp);
    checkOutput({tag, "_rdy"}, {31'd0, busReady}, {31'd0, rdy});
    checkOutput({tag, "_resp"}, {31'd0, busResp}, {31'd0, resp});
  endtask

  initial begin
    HRESET = 1'b1;
    target = 2'd0;
    hwdata = 32'd0;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    tick();
    HRESET = 1'b0;
    checkBus("reset", 1'b1, 1'b0);
    checkOutput("reset_rdata", busRdata, 32'h0);

    // Zero-wait write then SEQ read of the same word, forwarded.
    applyStimulus(1'b1, T_NONSEQ, 32'h0, 1'b1, SZ_WORD);
    tick();
    checkBus("pipe_wr", 1'b1, 1'b0);
    hwdata = 32'hDEADBEEF;
    applyStimulus(1'b1, T_SEQ, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkBus("pipe_rd", 1'b1, 1'b0);
    checkOutput("pipe_fwd", busRdata, 32'hDEADBEEF);
    hwdata = 32'h0;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();

    applyStimulus(1'b1, T_NONSEQ, 32'h4, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'h11223344;
    applyStimulus(1'b1, T_NONSEQ, 32'h6, 1'b1, SZ_BYTE);
    tick();
    hwdata = 32'h00AA0000;
    applyStimulus(1'b1, T_NONSEQ, 32'h4, 1'b0, SZ_WORD);
    tick();
    checkOutput("lane_fwd", busRdata, 32'h11AA3344);
    hwdata = 32'h0;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    applyStimulus(1'b1, T_NONSEQ, 32'h4, 1'b0, SZ_WORD);
    tick();
    checkOutput("lane_mem", busRdata, 32'h11AA3344);
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();

    // Out of range write aliases word 0 if it leaked through.
    applyStimulus(1'b1, T_NONSEQ, 32'h1000, 1'b1, SZ_WORD);
    tick();
    checkBus("oor_err1", 1'b0, 1'b1);
    hwdata = 32'hFFFFFFFF;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkBus("oor_err2", 1'b1, 1'b1);
    checkOutput("oor_hold", busRdata, 32'h11AA3344);
    hwdata = 32'h0;
    tick();
    checkBus("oor_idle", 1'b1, 1'b0);
    applyStimulus(1'b1, T_NONSEQ, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkOutput("oor_mem", busRdata, 32'hDEADBEEF);
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();

    applyStimulus(1'b1, T_NONSEQ, 32'h1, 1'b0, SZ_HALF);
    tick();
    checkBus("ual_err1", 1'b0, 1'b1);
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkBus("ual_err2", 1'b1, 1'b1);
    checkOutput("ual_hold", busRdata, 32'hDEADBEEF);
    tick();

    // Oversize beat, with a legal read pipelined behind the ERR2 cycle.
    applyStimulus(1'b1, T_NONSEQ, 32'h8, 1'b0, 3'd3);
    tick();
    checkBus("big_err1", 1'b0, 1'b1);
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkBus("big_err2", 1'b1, 1'b1);
    applyStimulus(1'b1, T_NONSEQ, 32'h4, 1'b0, SZ_WORD);
    tick();
    checkBus("big_next", 1'b1, 1'b0);
    checkOutput("big_next_data", busRdata, 32'h11AA3344);
    applyStimulus(1'b0, T_NONSEQ, 32'h0, 1'b1, SZ_WORD);
    tick();
    checkBus("nosel", 1'b1, 1'b0);
    hwdata = 32'h12345678;
    applyStimulus(1'b1, T_BUSY, 32'h0, 1'b1, SZ_WORD);
    tick();
    checkBus("busy", 1'b1, 1'b0);
    applyStimulus(1'b1, T_IDLE, 32'h0, 1'b1, SZ_WORD);
    tick();
    checkBus("idle", 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, T_NONSEQ, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkOutput("ignored_mem", busRdata, 32'hDEADBEEF);
    hwdata = 32'h0;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();

    // Two wait states.
    target = 2'd2;
    applyStimulus(1'b1, T_NONSEQ, 32'h8, 1'b1, SZ_WORD);
    tick();
    checkBus("ws_wr_w1", 1'b0, 1'b0);
    hwdata = 32'hCAFEF00D;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkBus("ws_wr_w2", 1'b0, 1'b0);
    tick();
    checkBus("ws_wr_data", 1'b1, 1'b0);
    tick();
    hwdata = 32'h0;
    applyStimulus(1'b1, T_NONSEQ, 32'h8, 1'b0, SZ_WORD);
    tick();
    checkBus("ws_rd_w1", 1'b0, 1'b0);
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    checkBus("ws_rd_w2", 1'b0, 1'b0);
    tick();
    checkBus("ws_rd_data", 1'b1, 1'b0);
    checkOutput("ws_rd_value", busRdata, 32'hCAFEF00D);
    tick();
    checkBus("ws_rd_after", 1'b1, 1'b0);
    checkOutput("ws_rd_hold", busRdata, 32'hCAFEF00D);

    // Three wait states, reset in the middle of a read.
    target = 2'd3;
    applyStimulus(1'b1, T_NONSEQ, 32'h10, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'h0BADCAFE;
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    tick();
    tick();
    checkBus("ws3_wr_data", 1'b1, 1'b0);
    tick();
    hwdata = 32'h0;
    applyStimulus(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_WORD);
    tick();
    checkBus("rst_midwait", 1'b0, 1'b0);
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    checkBus("rst_abort", 1'b1, 1'b0);
    checkOutput("rst_abort_rdata", busRdata, 32'h0);
    applyStimulus(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_WORD);
    tick();
    applyStimulus(1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD);
    tick();
    tick();
    tick();
    checkBus("rst_keep", 1'b1, 1'b0);
    checkOutput("rst_keep_mem", busRdata, 32'h0BADCAFE);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
